// File: rtl/riscv_dmem.sv
// Data-memory responder for the single-cycle core: word RAM plus a small MMIO block
// (GPIO, cycle counter, compare timer, console TX FIFO). Reads are combinational, writes commit on clk.
module riscv_dmem #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] gpio_out,
    output logic        timer_flag,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;

    localparam logic [FAW-1:0] PTR_ONE  = FAW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [5:0] OFF_GPIO   = 6'h00;
    localparam logic [5:0] OFF_CYCLE  = 6'h01;
    localparam logic [5:0] OFF_CMP    = 6'h02;
    localparam logic [5:0] OFF_TSTAT  = 6'h03;
    localparam logic [5:0] OFF_TXDATA = 6'h04;
    localparam logic [5:0] OFF_TXSTAT = 6'h05;

    logic [31:0]    mem_q [RAM_WORDS];
    logic [7:0]     fifo_q [FIFO_DEPTH];

    logic [31:0]    gpio_q, gpio_d;
    logic [31:0]    cycle_q, cycle_d;
    logic [31:0]    cmp_q, cmp_d;
    logic           flag_q, flag_d;
    logic [FAW-1:0] wptr_q, wptr_d;
    logic [FAW-1:0] rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;

    logic           ram_sel_s, io_sel_s, unused_addr_s;
    logic [RAW-1:0] ram_idx_s;
    logic [5:0]     io_off_s;
    logic           wr_ram_s, wr_io_s;
    logic           push_s, pop_s, full_s, empty_s, push_ok_s, ovf_set_s;
    logic [7:0]     cnt8_s;

    assign ram_sel_s     = (a[31:28] == 4'h0);
    assign io_sel_s      = (a[31:28] == 4'hF);
    assign ram_idx_s     = a[RAW+1:2];
    assign io_off_s      = a[7:2];
    assign unused_addr_s = ^{a[27:8], a[1:0]};
    assign wr_ram_s      = we & ram_sel_s;
    assign wr_io_s       = we & io_sel_s;

    // FIFO status; pop depends on tx_ready but only feeds next-state logic, never rd
    assign empty_s   = (count_q == CNT_ZERO);
    assign full_s    = (count_q == CNT_FULL);
    assign push_s    = wr_io_s & (io_off_s == OFF_TXDATA);
    assign pop_s     = ~empty_s & tx_ready;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;
    assign cnt8_s    = 8'(count_q);

    // Next-state logic for MMIO registers, timer and FIFO bookkeeping
    always_comb begin
        cycle_d = cycle_q + 32'd1;

        if (wr_io_s && (io_off_s == OFF_GPIO)) gpio_d = wd;
        else                                   gpio_d = gpio_q;

        if (wr_io_s && (io_off_s == OFF_CMP)) cmp_d = wd;
        else                                  cmp_d = cmp_q;

        if (cycle_q == cmp_q)                                  flag_d = 1'b1;
        else if (wr_io_s && (io_off_s == OFF_TSTAT) && wd[0]) flag_d = 1'b0;
        else                                                   flag_d = flag_q;

        if (ovf_set_s)                                          ovf_d = 1'b1;
        else if (wr_io_s && (io_off_s == OFF_TXSTAT) && wd[2]) ovf_d = 1'b0;
        else                                                    ovf_d = ovf_q;

        if (push_ok_s) wptr_d = wptr_q + PTR_ONE;
        else           wptr_d = wptr_q;

        if (pop_s) rptr_d = rptr_q + PTR_ONE;
        else       rptr_d = rptr_q;

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; RAM and FIFO storage are not reset
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q  <= 32'h0000_0000;
            cycle_q <= 32'h0000_0000;
            cmp_q   <= 32'hFFFF_FFFF;
            flag_q  <= 1'b0;
            wptr_q  <= {FAW{1'b0}};
            rptr_q  <= {FAW{1'b0}};
            count_q <= CNT_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage arrays; a write presented during reset is discarded
    always_ff @(posedge clk) begin
        if (!reset && wr_ram_s) begin
            mem_q[ram_idx_s] <= wd;
        end
        if (!reset && push_ok_s) begin
            fifo_q[wptr_q] <= wd[7:0];
        end
    end

    // Zero-latency read mux
    always_comb begin
        rd = 32'h0000_0000;
        if (ram_sel_s) begin
            rd = mem_q[ram_idx_s];
        end else if (io_sel_s) begin
            case (io_off_s)
                OFF_GPIO:   rd = gpio_q;
                OFF_CYCLE:  rd = cycle_q;
                OFF_CMP:    rd = cmp_q;
                OFF_TSTAT:  rd = {31'h0000_0000, flag_q};
                OFF_TXSTAT: rd = {16'h0000, cnt8_s, 5'b00000, ovf_q, empty_s, full_s};
                default:    rd = 32'h0000_0000;
            endcase
        end else begin
            rd = {31'h0000_0000, unused_addr_s & 1'b0};
        end
    end

    assign gpio_out   = gpio_q;
    assign timer_flag = flag_q;
    assign tx_valid   = ~empty_s;
    assign tx_data    = fifo_q[rptr_q];

endmodule

// File: tb/tb_riscv_dmem.sv
// Scoreboard bench for riscv_dmem: stimulus queues expectations, negedge monitors compare them.
module tb_riscv_dmem;

    localparam int RAM_WORDS = 1024;
    localparam int SEL_RD = 0, SEL_GPIO = 1, SEL_FLAG = 2, SEL_TXV = 3, SEL_TXD = 4;
    localparam logic [31:0] A_GPIO = 32'hF000_0000, A_CYCLE = 32'hF000_0004, A_CMP = 32'hF000_0008;
    localparam logic [31:0] A_TSTAT = 32'hF000_000C, A_TXDATA = 32'hF000_0010, A_TXSTAT = 32'hF000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd, gpio_out;
    logic        timer_flag, tx_valid, tx_ready = 1'b0;
    logic [7:0]  tx_data;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int          cyc = 0;
    int          rst_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    riscv_dmem #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
        .gpio_out(gpio_out), .timer_flag(timer_flag), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int elapsed();
        return cyc - rst_cyc;
    endfunction

    function automatic logic [31:0] observe(int sel);
        case (sel)
            SEL_RD:   return rd;
            SEL_GPIO: return gpio_out;
            SEL_FLAG: return {31'h0, timer_flag};
            SEL_TXV:  return {31'h0, tx_valid};
            default:  return {24'h0, tx_data};
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            got = observe(e.sel);
            n_checks++;
            if (got === e.exp) n_pass++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
        end
    end

    // Monitor: every byte leaving the FIFO must match the expected stream
    always @(negedge clk) begin
        logic [7:0] eb;
        if (tx_valid && tx_ready) begin
            n_checks++;
            if (tx_exp_q.size() == 0) begin
                $display("FAIL tx_extra: got 0x%02h expected no byte", tx_data);
            end else begin
                eb = tx_exp_q.pop_front();
                if (tx_data === eb) n_pass++;
                else $display("FAIL tx_byte: got 0x%02h expected 0x%02h", tx_data, eb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(int sel, logic [31:0] exp, string name);
        exp_q.push_back('{cyc, sel, exp, name});
    endtask

    task automatic wr(logic [31:0] addr, logic [31:0] data);
        a = addr; wd = data; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd_chk(logic [31:0] addr, logic [31:0] exp, string name);
        we = 1'b0; a = addr;
        expect_now(SEL_RD, exp, name);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tgt;
        repeat (3) step();
        reset = 1'b0;
        rst_cyc = cyc;
        expect_now(SEL_GPIO, 32'h0, "gpio_rst");
        expect_now(SEL_FLAG, 32'h0, "flag_rst");
        expect_now(SEL_TXV, 32'h0, "txv_rst");
        rd_chk(A_CYCLE, 32'd0, "cycle_rst");
        rd_chk(A_CMP, 32'hFFFF_FFFF, "cmp_rst");
        rd_chk(A_TXSTAT, 32'h0000_0002, "txstat_rst");

        // Timer: match at CYCLE==20, sticky, clear, then set beats clear
        wr(A_CMP, 32'd20);
        while (elapsed() < 20) step();
        expect_now(SEL_FLAG, 32'h0, "flag_pre_match");
        rd_chk(A_CYCLE, 32'd20, "cycle_at_match");
        expect_now(SEL_FLAG, 32'h1, "flag_set");
        step();
        expect_now(SEL_FLAG, 32'h1, "flag_sticky");
        rd_chk(A_TSTAT, 32'h1, "tstat_read");
        wr(A_TSTAT, 32'h1);
        expect_now(SEL_FLAG, 32'h0, "flag_clear");
        tgt = elapsed() + 4;
        wr(A_CMP, 32'(tgt));
        while (elapsed() < tgt) step();
        wr(A_TSTAT, 32'h1);
        expect_now(SEL_FLAG, 32'h1, "flag_set_wins");
        wr(A_TSTAT, 32'h1);
        expect_now(SEL_FLAG, 32'h0, "flag_clear2");

        // RAM: readback, aliasing, unmapped region, read-before-write
        wr(32'h0000_0010, 32'h1234_5678);
        rd_chk(32'h0000_0010, 32'h1234_5678, "ram_rdback");
        rd_chk(32'h0000_0010 + 4 * RAM_WORDS, 32'h1234_5678, "ram_alias");
        rd_chk(32'h4000_0000, 32'h0, "unmapped_rd");
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h4000_0000, 32'hDEAD_BEEF);
        rd_chk(32'h0000_0000, 32'h1111_1111, "unmapped_wr_drop");
        a = 32'h0000_0010; wd = 32'hCAFE_F00D; we = 1'b1;
        expect_now(SEL_RD, 32'h1234_5678, "rd_prewrite");
        step();
        we = 1'b0;
        rd_chk(32'h0000_0013, 32'hCAFE_F00D, "ram_byteoff");

        // GPIO and cycle counter
        wr(A_GPIO, 32'h0000_00A5);
        expect_now(SEL_GPIO, 32'h0000_00A5, "gpio_out");
        rd_chk(A_GPIO, 32'h0000_00A5, "gpio_rd");
        rd_chk(A_CYCLE, 32'(elapsed()), "cycle_n");
        rd_chk(A_CYCLE, 32'(elapsed()), "cycle_n1");
        wr(A_CYCLE, 32'h0);
        rd_chk(A_CYCLE, 32'(elapsed()), "cycle_wr_ignored");

        // FIFO overflow and in-order drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'h41 + 32'(i));
        for (int i = 0; i < 4; i++) tx_exp_q.push_back(8'h41 + 8'(i));
        expect_now(SEL_TXD, 32'h41, "tx_head");
        rd_chk(A_TXSTAT, 32'h0000_0405, "txstat_ovf_full");
        rd_chk(A_TXDATA, 32'h0, "txdata_rd_zero");
        tx_ready = 1'b1;
        repeat (4) step();
        expect_now(SEL_TXV, 32'h0, "txv_drained");
        rd_chk(A_TXSTAT, 32'h0000_0006, "txstat_empty_ovf");
        tx_ready = 1'b0;
        wr(A_TXSTAT, 32'h4);
        rd_chk(A_TXSTAT, 32'h0000_0002, "txstat_ovf_clr");

        // Push while full with simultaneous pop
        for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'h61 + 32'(i));
        for (int i = 0; i < 4; i++) tx_exp_q.push_back(8'h61 + 8'(i));
        rd_chk(A_TXSTAT, 32'h0000_0401, "txstat_full");
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h55);
        tx_ready = 1'b0;
        tx_exp_q.push_back(8'h55);
        rd_chk(A_TXSTAT, 32'h0000_0401, "txstat_pushpop");
        wr(A_TXDATA, 32'h77);
        rd_chk(A_TXSTAT, 32'h0000_0405, "txstat_drop");
        wr(A_TXSTAT, 32'h4);
        rd_chk(A_TXSTAT, 32'h0000_0401, "txstat_clr2");
        tx_ready = 1'b1;
        repeat (4) step();
        expect_now(SEL_TXV, 32'h0, "txv_drained2");
        rd_chk(A_TXSTAT, 32'h0000_0002, "txstat_empty2");

        // Push and pop request while empty: push accepted, no pop
        a = A_TXDATA; wd = 32'h99; we = 1'b1;
        step();
        we = 1'b0; tx_ready = 1'b0;
        expect_now(SEL_TXD, 32'h99, "tx_empty_push");
        rd_chk(A_TXSTAT, 32'h0000_0100, "txstat_one");

        // Reset mid-operation with 3 bytes queued and CYCLE==100
        while (elapsed() < 97) step();
        wr(A_TXDATA, 32'h9A);
        wr(A_TXDATA, 32'h9B);
        rd_chk(A_TXSTAT, 32'h0000_0300, "txstat_three");
        reset = 1'b1; a = 32'h0000_0010; wd = 32'hBAD0_BAD0; we = 1'b1;
        expect_now(SEL_TXV, 32'h1, "txv_before_rst");
        step();
        reset = 1'b0; we = 1'b0;
        rst_cyc = cyc;
        expect_now(SEL_TXV, 32'h0, "txv_after_rst");
        expect_now(SEL_GPIO, 32'h0, "gpio_after_rst");
        rd_chk(A_CYCLE, 32'd0, "cycle_after_rst");
        rd_chk(A_CMP, 32'hFFFF_FFFF, "cmp_after_rst");
        rd_chk(32'h0000_0010, 32'hCAFE_F00D, "ram_kept");
        rd_chk(A_TXSTAT, 32'h0000_0002, "txstat_after_rst");

        step();
        step();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL exp_queue_drain: got %0d pending expected 0", exp_q.size());
        n_checks++;
        if (tx_exp_q.size() == 0) n_pass++;
        else $display("FAIL tx_queue_drain: got %0d pending expected 0", tx_exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_dmem.md
Name: riscv_dmem

Overview:
- Data-memory responder on the core's data port. The core drives the write enable, the address and the write data; this block returns the read data.
- Holds a word-addressed RAM and a small memory-mapped I/O region: GPIO output register, free-running cycle counter, compare timer with a sticky flag, and a byte-wide console TX FIFO.
- Sits beside the core at top level, wired to the core's wem, rwam, wdm and rdm.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words (power of 2).
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable from core (wem).
- a  in  32  byte address from core (rwam).
- wd  in  32  write data from core (wdm).
- rd  out  32  read data to core (rdm), combinational.
- gpio_out  out  32  GPIO output register.
- timer_flag  out  1  sticky compare-match flag.
- tx_valid  out  1  FIFO non-empty.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts the head byte this cycle.

Behaviour:
- One clock; reset is synchronous and active-high.
- Decode:
  - a[31:28]==0x0 selects RAM. Word index is a[log2(RAM_WORDS)+1:2]; higher bits are ignored, so addresses alias and wrap.
  - a[31:28]==0xF selects MMIO, with offset a[7:0]; a[1:0] are ignored everywhere.
  - Any other address: reads return 0 and writes are dropped.
- Reads: rd is a combinational function of a and the current state, with zero latency, as the single-cycle core needs.
- Writes: committed on the rising clk edge when we=1. A read in the same cycle returns the pre-write value.
- MMIO map:
  - 0x00 GPIO: read/write.
  - 0x04 CYCLE: read-only, increments by 1 every cycle and wraps from 0xFFFFFFFF to 0. Writes are ignored.
  - 0x08 CMP: read/write.
  - 0x0C TSTAT: bit0 = timer_flag. Writing wd[0]=1 clears the flag.
  - 0x10 TXDATA: write pushes wd[7:0]. Reads return 0.
  - 0x14 TXSTAT: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count. Writing wd[2]=1 clears overflow.
  - Other offsets: read 0, writes ignored.
- Timer:
  - At each edge where CYCLE==CMP (pre-increment values), timer_flag is set.
  - A CMP write takes effect for the next cycle's compare.
  - If a set and a clear occur in the same cycle, set wins.
- TX FIFO:
  - Circular buffer with read pointer, write pointer and a count of width log2(FIFO_DEPTH)+1.
  - Pop happens when tx_valid and tx_ready are both 1.
  - Push happens on a TXDATA write.
  - Push with count<FIFO_DEPTH is accepted.
  - Push while full with a pop in the same cycle is accepted; count is unchanged.
  - Push while full without a pop is dropped and sets overflow. An overflow set beats an overflow clear in the same cycle.
  - Simultaneous push and pop when empty: the push is accepted and the pop does not occur (tx_valid was 0).
  - tx_data is the head byte; its value is don't-care when empty.
- Reset values:
  - gpio_out=0, CYCLE=0, CMP=0xFFFFFFFF, timer_flag=0.
  - FIFO pointers=0, count=0, overflow=0, so tx_valid=0.
  - RAM contents are not reset. Reset mid-operation discards FIFO contents, and any write presented in the reset cycle is dropped.
- rd mux must not create a combinational path from tx_ready.

Test Plan:
- Reset, then write 0x12345678 to 0x00000010 and read it back → rd=0x12345678. Read 0x00000010+4*RAM_WORDS → same value (alias). Read 0x40000000 → 0.
- Write 0xA5 to GPIO 0xF0000000 → gpio_out=0x000000A5 after the edge. Reads of 0xF0000004 on consecutive cycles → increasing by 1; value N cycles after reset release is N.
- Write CMP=20 → timer_flag rises at the edge where CYCLE==20. Write 1 to 0xF000000C → flag clears. Clear issued in the match cycle → flag stays 1.
- tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 → TXSTAT=0x0405 (count 4, overflow, full). Then tx_ready=1 → bytes out 0x41..0x44 in order, one per cycle, and tx_valid drops.
- FIFO full, push 0x55 with tx_ready=1 in the same cycle → accepted, count stays 4, overflow unchanged. Write 0x4 to TXSTAT → overflow cleared.
- Assert reset with the FIFO holding 3 bytes and CYCLE=100 → next cycle tx_valid=0, CYCLE reads 0, CMP reads 0xFFFFFFFF, and RAM data written earlier is still readable.
